// File: rtl/sram_bank_gate_ctrl.sv
// rtl/sram_bank_gate_ctrl.sv - per-bank clock-gate sequencer for the four MACB SRAM banks
//
// Each bank runs its own ON / GATED / WAKE FSM. In ON the bank gates after
// idle_limit idle cycles (when auto_gate_en) or on force_gate. In GATED only
// an access wakes it. WAKE runs the bank clock for WAKE_CYCLES cycles before
// bank_ready rises.
//
// Optional feature macro: SRAM_GATE_CTRL_WAKE_STATS_EN
//   defined   : wake_count is a saturating count of wake events
//   undefined : wake_count is tied to 16'h0
//
// Ports:
//   hclk, n_hreset       clock, asynchronous active-low reset
//   auto_gate_en         enables idle-timeout gating
//   idle_limit           idle cycles before auto-gate (0 disables auto-gate)
//   force_gate[3:0]      per-bank gate request (level)
//   bank_access[3:0]     per-bank access request, held until bank_ready
//   bank_ready[3:0]      1 = access completes this cycle
//   clk_sram_en[3:0]     per-bank clock enable
//   gated_status[3:0]    1 = bank GATED
//   all_gated            AND of gated_status
//   wake_count[15:0]     total wake events, saturating

module sram_bank_gate_ctrl #(
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              hclk,
    input  logic              n_hreset,
    input  logic              auto_gate_en,
    input  logic [IDLE_W-1:0] idle_limit,
    input  logic [3:0]        force_gate,
    input  logic [3:0]        bank_access,
    output logic [3:0]        bank_ready,
    output logic [3:0]        clk_sram_en,
    output logic [3:0]        gated_status,
    output logic              all_gated,
    output logic [15:0]       wake_count
);

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } bank_state_e;

    localparam logic [3:0]      WAKE_LAST = 4'(WAKE_CYCLES - 1);
    localparam logic [IDLE_W:0] ONE_EXT   = (IDLE_W+1)'(1);

    bank_state_e       state_q    [4];
    bank_state_e       state_d    [4];
    logic [IDLE_W-1:0] idle_cnt_q [4];
    logic [IDLE_W-1:0] idle_cnt_d [4];
    logic [3:0]        wake_cnt_q [4];
    logic [3:0]        wake_cnt_d [4];

    always_ff @(posedge hclk or negedge n_hreset) begin
        if (!n_hreset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]    <= ST_ON;
                idle_cnt_q[i] <= '0;
                wake_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]    <= state_d[i];
                idle_cnt_q[i] <= idle_cnt_d[i];
                wake_cnt_q[i] <= wake_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i]    = state_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            wake_cnt_d[i] = wake_cnt_q[i];
            case (state_q[i])
                ST_ON: begin
                    // Access beats both forced and timed gating in the same cycle.
                    if (bank_access[i]) begin
                        idle_cnt_d[i] = '0;
                    end else if (force_gate[i]) begin
                        state_d[i]    = ST_GATED;
                        idle_cnt_d[i] = '0;
                    end else if (auto_gate_en && (idle_limit != '0) &&
                                 (({1'b0, idle_cnt_q[i]} + ONE_EXT) >= {1'b0, idle_limit})) begin
                        // Extended compare so a saturated counter still reaches the limit.
                        state_d[i]    = ST_GATED;
                        idle_cnt_d[i] = '0;
                    end else if (idle_cnt_q[i] != '1) begin
                        idle_cnt_d[i] = idle_cnt_q[i] + IDLE_W'(1);
                    end
                end
                ST_GATED: begin
                    idle_cnt_d[i] = '0;
                    if (bank_access[i]) begin
                        state_d[i]    = ST_WAKE;
                        wake_cnt_d[i] = '0;
                    end
                end
                ST_WAKE: begin
                    // force_gate is deliberately ignored until the held access completes.
                    if (wake_cnt_q[i] == WAKE_LAST) begin
                        state_d[i]    = ST_ON;
                        idle_cnt_d[i] = '0;
                        wake_cnt_d[i] = '0;
                    end else begin
                        wake_cnt_d[i] = wake_cnt_q[i] + 4'd1;
                    end
                end
                default: begin
                    state_d[i]    = ST_ON;
                    idle_cnt_d[i] = '0;
                    wake_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_comb begin
        clk_sram_en  = '0;
        bank_ready   = '0;
        gated_status = '0;
        for (int i = 0; i < 4; i++) begin
            clk_sram_en[i]  = (state_q[i] != ST_GATED);
            bank_ready[i]   = (state_q[i] == ST_ON);
            gated_status[i] = (state_q[i] == ST_GATED);
        end
        all_gated = &gated_status;
    end

`ifdef SRAM_GATE_CTRL_WAKE_STATS_EN
    logic [2:0]  n_wake;
    logic [16:0] wake_sum;
    logic [15:0] wake_count_q;

    always_comb begin
        n_wake = '0;
        for (int i = 0; i < 4; i++) begin
            if ((state_q[i] == ST_GATED) && bank_access[i]) begin
                n_wake = n_wake + 3'd1;
            end
        end
        wake_sum = {1'b0, wake_count_q} + {14'd0, n_wake};
    end

    always_ff @(posedge hclk or negedge n_hreset) begin
        if (!n_hreset) begin
            wake_count_q <= '0;
        end else begin
            wake_count_q <= wake_sum[16] ? 16'hFFFF : wake_sum[15:0];
        end
    end

    assign wake_count = wake_count_q;
`else
    assign wake_count = 16'h0;
`endif

endmodule

// File: tb/tb_sram_bank_gate_ctrl.sv
// tb/tb_sram_bank_gate_ctrl.sv - self-checking bench for sram_bank_gate_ctrl
module tb_sram_bank_gate_ctrl;

    logic        hclk;
    logic        n_hreset;
    logic        auto_gate_en;
    logic [7:0]  idle_limit;
    logic [3:0]  force_gate;
    logic [3:0]  bank_access;
    logic [3:0]  bank_ready;
    logic [3:0]  clk_sram_en;
    logic [3:0]  gated_status;
    logic        all_gated;
    logic [15:0] wake_count;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef SRAM_GATE_CTRL_WAKE_STATS_EN
    localparam logic [15:0] WC_MASK = 16'hFFFF;
`else
    localparam logic [15:0] WC_MASK = 16'h0000;
`endif

    sram_bank_gate_ctrl #(.IDLE_W(8), .WAKE_CYCLES(2)) dut (
        .hclk         (hclk),
        .n_hreset     (n_hreset),
        .auto_gate_en (auto_gate_en),
        .idle_limit   (idle_limit),
        .force_gate   (force_gate),
        .bank_access  (bank_access),
        .bank_ready   (bank_ready),
        .clk_sram_en  (clk_sram_en),
        .gated_status (gated_status),
        .all_gated    (all_gated),
        .wake_count   (wake_count)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0] access;
        logic [3:0] force_g;
        logic [3:0] en;
        logic [3:0] rdy;
        logic [3:0] gated;
        logic       all;
        int         wc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [3:0] e, input logic [3:0] r,
                       input logic [3:0] g, input logic a, input int w);
        logic [28:0] act;
        logic [28:0] exp;
        act = {clk_sram_en, bank_ready, gated_status, all_gated, wake_count};
        exp = {e, r, g, a, (16'(w) & WC_MASK)};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got en/rdy/gated/all/wc=%h/%h/%h/%b/%h, required %h/%h/%h/%b/%h",
                     nm, clk_sram_en, bank_ready, gated_status, all_gated, wake_count,
                     e, r, g, a, (16'(w) & WC_MASK));
        end
    endtask

    task automatic step(input logic [3:0] acc, input logic [3:0] frc);
        bank_access = acc;
        force_gate  = frc;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // access force   en     rdy    gated  all  wc
        vecs[0] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 0};
        vecs[1] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 0};
        vecs[2] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 0};
        vecs[3] = '{4'h1, 4'h0, 4'h1, 4'h1, 4'hE, 1'b0, 0};
        vecs[4] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hE, 1'b0, 0};
        vecs[5] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hE, 1'b0, 0};
        vecs[6] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hE, 1'b0, 0};
        vecs[7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 0};
        vecs[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 0};

        n_hreset     = 1'b0;
        auto_gate_en = 1'b1;
        idle_limit   = 8'd4;
        force_gate   = 4'h0;
        bank_access  = 4'h0;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset", 4'hF, 4'hF, 4'h0, 1'b0, 0);
        n_hreset = 1'b1;

        // Idle timeout from reset, bank0 kept alive by one access.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].access, vecs[i].force_g);
            chk($sformatf("vec%0d", i), vecs[i].en, vecs[i].rdy, vecs[i].gated,
                vecs[i].all, vecs[i].wc);
        end

        // Bank2 wake: en at +1, ready at +WAKE_CYCLES+1, then forced gate.
        step(4'h4, 4'h0); chk("b2_wake0", 4'h4, 4'h0, 4'hB, 1'b0, 1);
        step(4'h4, 4'h0); chk("b2_wake1", 4'h4, 4'h0, 4'hB, 1'b0, 1);
        step(4'h4, 4'h0); chk("b2_on",    4'h4, 4'h4, 4'hB, 1'b0, 1);
        step(4'h0, 4'h4); chk("b2_force", 4'h0, 4'h0, 4'hF, 1'b1, 1);
        step(4'h0, 4'h0); chk("b2_stay",  4'h0, 4'h0, 4'hF, 1'b1, 1);

        // Bank1: access beats force in the same cycle.
        step(4'h2, 4'h0); chk("b1_wake0",   4'h2, 4'h0, 4'hD, 1'b0, 2);
        step(4'h2, 4'h0); chk("b1_wake1",   4'h2, 4'h0, 4'hD, 1'b0, 2);
        step(4'h2, 4'h0); chk("b1_on",      4'h2, 4'h2, 4'hD, 1'b0, 2);
        step(4'h2, 4'h2); chk("b1_acc_frc", 4'h2, 4'h2, 4'hD, 1'b0, 2);
        step(4'h0, 4'h2); chk("b1_gate",    4'h0, 4'h0, 4'hF, 1'b1, 2);

        // Bank3: force during WAKE ignored until the access completes.
        step(4'h8, 4'h0); chk("b3_wake0",  4'h8, 4'h0, 4'h7, 1'b0, 3);
        step(4'h8, 4'h8); chk("b3_wake1",  4'h8, 4'h0, 4'h7, 1'b0, 3);
        step(4'h8, 4'h8); chk("b3_on",     4'h8, 4'h8, 4'h7, 1'b0, 3);
        step(4'h0, 4'h8); chk("b3_gate",   4'h0, 4'h0, 4'hF, 1'b1, 3);
        step(4'h0, 4'h0); chk("b3_nowake", 4'h0, 4'h0, 4'hF, 1'b1, 3);

        // All four banks wake together.
        step(4'hF, 4'h0); chk("all_wake0", 4'hF, 4'h0, 4'h0, 1'b0, 7);
        step(4'hF, 4'h0); chk("all_wake1", 4'hF, 4'h0, 4'h0, 1'b0, 7);
        step(4'hF, 4'h0); chk("all_on",    4'hF, 4'hF, 4'h0, 1'b0, 7);

        // idle_limit = 0 disables auto-gate; counter must saturate, not wrap.
        idle_limit = 8'd0;
        for (int i = 0; i < 300; i++) begin
            step(4'h0, 4'h0);
            chk($sformatf("lim0_c%0d", i), 4'hF, 4'hF, 4'h0, 1'b0, 7);
        end
        idle_limit = 8'd200;
        step(4'h0, 4'h0); chk("live_limit", 4'h0, 4'h0, 4'hF, 1'b1, 7);

        // Asynchronous reset in the middle of WAKE.
        idle_limit = 8'd4;
        step(4'h1, 4'h0); chk("pre_rst_wake", 4'h1, 4'h0, 4'hE, 1'b0, 8);
        #2;
        n_hreset = 1'b0;
        #1;
        chk("async_rst", 4'hF, 4'hF, 4'h0, 1'b0, 0);
        @(posedge hclk);
        #1;
        n_hreset = 1'b1;

        // auto_gate_en = 0: no timed gating.
        auto_gate_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(4'h0, 4'h0);
            chk($sformatf("noauto_c%0d", i), 4'hF, 4'hF, 4'h0, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bank_gate_ctrl.md
Name: sram_bank_gate_ctrl

Overview:
- Per-bank clock-gate sequencer for the four 32 KB MACB SRAM banks in the SRAM subsystem.
- Drives the active-high clock-enable inputs of each bank (clk_SRPG_macb0..3_en; 1 = bank clock running). It gates a bank after a programmable idle period or on a forced request.
- Wakes a bank on demand and stalls the pending access via bank_ready until the bank clock has been running for WAKE_CYCLES cycles.
- Sits between the AHB address decode (haddr[17:15]) and the bank wrappers. The instantiator folds ~bank_ready into the subsystem hready.

Parameters:
- IDLE_W, 8: width of the idle counter and of idle_limit.
- WAKE_CYCLES, 2: cycles the bank clock runs before bank_ready rises. Legal range 1..15.

Ports:
- hclk  in  1  AHB clock
- n_hreset  in  1  reset, asynchronous, active-low
- auto_gate_en  in  1  enables idle-timeout gating
- idle_limit  in  IDLE_W  idle cycles before auto-gate; 0 disables auto-gate
- force_gate  in  4  per-bank gate request from the power manager (level)
- bank_access  in  4  per-bank access request, level; held by the requester until bank_ready is 1
- bank_ready  out  4  1 = access to the bank completes this cycle
- clk_sram_en  out  4  per-bank clock enable, to clk_SRPG_macbN_en
- gated_status  out  4  1 = bank in GATED state
- all_gated  out  1  AND of gated_status
- wake_count  out  16  total wake events, saturating (see Optional Feature)

Behaviour:
- Four identical independent FSMs. Each has states ON, GATED, WAKE, an idle counter idle_cnt[IDLE_W-1:0] and a wake counter wake_cnt[3:0]. All outputs are registered or decoded from state only.
- Reset values: state = ON, idle_cnt = 0, wake_cnt = 0. Outputs: clk_sram_en = 4'hF, bank_ready = 4'hF, gated_status = 0, all_gated = 0, wake_count = 0.
- ON: en = 1, ready = 1.
  - If bank_access = 1: idle_cnt <= 0, stay ON. An access always beats gating in the same cycle.
  - Else if force_gate = 1: go to GATED.
  - Else if auto_gate_en = 1, idle_limit != 0 and idle_cnt + 1 >= idle_limit: go to GATED.
  - Else idle_cnt increments, saturating at all-ones.
  - Net effect: with the last access in cycle t and no further access or force, GATED is entered in cycle t + idle_limit + 1.
- GATED: en = 0, ready = 0, idle_cnt = 0.
  - bank_access = 1: go to WAKE with wake_cnt <= 0, and increment wake_count.
  - Deasserting force_gate does not wake the bank. Only an access wakes it.
- WAKE: en = 1, ready = 0. wake_cnt increments each cycle. When wake_cnt == WAKE_CYCLES-1, go to ON with idle_cnt = 0.
  - force_gate is ignored in WAKE. It is re-evaluated in ON, after the held access completes.
  - Latency: access seen in GATED at cycle t gives en = 1 at t+1 and ready = 1 at t + WAKE_CYCLES + 1.
- idle_limit changing mid-count uses the live value. If idle_cnt is already >= the new limit, the bank gates on the next idle cycle.
- Simultaneous events on different banks are fully independent. wake_count adds the number of banks entering WAKE in that cycle (0..4) and saturates at 16'hFFFF.
- Reset mid-WAKE or mid-GATED returns the bank to ON immediately, with en = 1 and ready = 1.
- bank_access on more than one bank in one cycle is legal. Each bank is handled independently.

Optional Feature:
- Macro: SRAM_GATE_CTRL_WAKE_STATS_EN.
- Defined: wake_count is implemented as described above.
- Undefined: wake_count is tied to 16'h0 and no counter logic is synthesised. The port stays present.

Test Plan:
- Reset, then idle_limit = 4, auto_gate_en = 1, single access bank0 at cycle 10 -> clk_sram_en[0] = 0 and gated_status[0] = 1 from cycle 15; banks 1-3 also gate after 4 idle cycles from reset.
- Bank2 GATED, bank_access[2] held from cycle 20, WAKE_CYCLES = 2 -> clk_sram_en[2] = 1 at 21, bank_ready[2] = 0 at 20-22, = 1 at 23, state ON; wake_count = 1.
- Bank1 ON, force_gate[1] = 1 with bank_access[1] = 1 in the same cycle -> stays ON with ready = 1; gates the next cycle after access drops.
- Bank3 in WAKE, force_gate[3] asserted -> completes wake, ready = 1 for the held access, then GATED the following cycle if force_gate is still set.
- idle_limit = 0 with auto_gate_en = 1, 300 idle cycles -> no bank gates, idle_cnt saturates at 255, clk_sram_en stays 4'hF.
- All four banks gated, simultaneous access on all four -> all_gated falls the next cycle, wake_count += 4. With the macro undefined, wake_count stays 0.
